alu_op_encoder: RTL and testbench
=================================

# alu_op_encoder

Registered ALU-control stage sitting in the ID/EX boundary of the pipeline. It decodes RV32I instruction fields into the 4-bit ALU operation code and operand-select controls consumed by the EX-stage ALU. It holds the decoded result in a pipeline register with valid, stall and flush handling.

## Interface
- `DATA_WIDTH`, 32: instruction width; the block supports only 32.
- `OPCODE_LENGTH`, 4: width of the ALU operation code.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  DATA_WIDTH  instruction word from the ID stage.
- `in_valid`  in  1  `instr` holds a real instruction; when 0 the input is a bubble.
- `stall`  in  1  hazard unit hold; the register keeps its contents.
- `flush`  in  1  branch/jump squash; the register is cleared to a bubble.
- `out_valid`  out  1  registered outputs describe a live instruction.
- `Operation`  out  OPCODE_LENGTH  ALU operation code.
- `alu_src_a_pc`  out  1  ALU SrcA is the PC; this is set for AUIPC only.
- `alu_src_b_imm`  out  1  ALU SrcB is the immediate; when 0, SrcB is rs2.
- `is_branch`  out  1  conditional branch; the ALU result bit 0 is the taken flag.
- `is_jump`  out  1  JAL or JALR.
- `illegal`  out  1  the instruction was rejected; this port exists only with the macro.

## Operation
- Operation code map:
  - AND 0000, XOR 0001, OR 0010, ADD 0011, SUB 0100.
  - EQ 0101, NE 0110, LT 0111, GE 1000.
  - SRL 1001, SLL 1010, SRA 1011.
  - PASS-B 1100, TRUE 1111.
  - The rejected/default code is 0000.
- Comparisons and LT/GE are signed; the ALU has no unsigned ops.
- R-type (opcode 0110011):
  - f3 000: ADD, or SUB when f7[5]=1.
  - f3 001: SLL. f3 010: LT. f3 100: XOR.
  - f3 101: SRL, or SRA when f7[5]=1.
  - f3 110: OR. f3 111: AND.
  - f3 011 (SLTU) is rejected.
  - f7 values other than 0000000 and 0100000 (the latter only with f3 000/101) are rejected.
- I-type ALU (0010011):
  - Same mapping as R-type, with `alu_src_b_imm`=1.
  - f3 000 is always ADD.
  - SLLI/SRLI require f7=0000000; SRAI requires f7=0100000; otherwise rejected.
  - SLTIU is rejected.
- LOAD (0000011), STORE (0100011), JALR (1100111): ADD with `alu_src_b_imm`=1. JALR also sets `is_jump`.
- BRANCH (1100011): `is_branch`=1 and `alu_src_b_imm`=0.
  - f3 000 EQ, 001 NE, 100 LT, 101 GE.
  - f3 010/011/110/111 are rejected.
- LUI (0110111): PASS-B with `alu_src_b_imm`=1.
- AUIPC (0010111): ADD with `alu_src_a_pc`=1 and `alu_src_b_imm`=1.
- JAL (1101111): TRUE, with `is_jump`=1.
- Any other opcode is rejected.
- A rejected instruction drives Operation 0000 and all select/flag outputs 0.

## Timing
- Latency: decode is combinational, registered once, so outputs appear 1 cycle after capture.
- Reset:
  - `out_valid`=0, `Operation`=0000.
  - All select, flag and `illegal` outputs are 0.
  - Reset takes effect immediately and asynchronously, including mid-stall.
- Register update priority per edge: flush > stall > load.
  - flush=1: `out_valid`=0 and all outputs return to reset values, regardless of stall or in_valid.
  - stall=1, flush=0: every output holds its value; `instr` is ignored.
  - Otherwise the register loads the decode of `instr`, and `out_valid`=`in_valid`.
- A bubble input (in_valid=0) loads reset values. Flags are never asserted with `out_valid`=0.
- Back-to-back instructions are accepted every cycle, with no internal state beyond the register.

## Configuration
- `ALU_ENC_ILLEGAL_TRAP_EN` defined:
  - A rejected instruction with in_valid=1 loads `illegal`=1 and `out_valid`=0, i.e. it becomes a bubble.
  - `illegal` is held under stall, cleared by flush, and cleared by the next non-stalled load.
- `ALU_ENC_ILLEGAL_TRAP_EN` undefined:
  - The `illegal` port is absent.
  - A rejected instruction propagates with `out_valid`=`in_valid` and Operation 0000 (AND), as a silent NOP-like op.

## Test plan
- Reset check: deassert rst_n mid-cycle with in_valid=1 -> all outputs are 0 immediately and stay 0 until the first edge after release.
- Decode sweep:
  - `0x40B50533` (sub a0,a0,a1) -> Operation 0100, src_b_imm 0, one cycle later.
  - `0x4055D593` (srai a1,a1,5) -> 1011, src_b_imm 1.
  - `0x00001137` (lui) -> 1100.
- Branches:
  - `0x00B50463` (beq) -> 0101, is_branch 1.
  - `0x00B54463` (blt) -> 0111.
  - `0x00B56463` (bltu) -> rejected.
- Stall/flush:
  - Load add, then stall 3 cycles with changing instr -> outputs frozen.
  - Assert stall+flush together -> out_valid 0 the next cycle.
- Jumps:
  - `0x0000006F` (jal) -> 1111, is_jump 1.
  - `0x00008067` (jalr) -> 0011, is_jump 1, src_b_imm 1.
  - `0x00000517` (auipc) -> 0011, src_a_pc 1.
- Illegal handling:
  - Opcode 0x7F or `0x00B53533` (sltu), in_valid 1 -> with the macro: illegal 1, out_valid 0.
  - Without the macro: out_valid 1, Operation 0000.

Source files
------------

// File: rtl/alu_op_encoder.sv
// ---------------------------------------------------------------------------
// alu_op_encoder
//   ID/EX ALU-control stage. Decodes RV32I instruction fields into a 4-bit
//   ALU operation code plus operand-select and control flags, and holds the
//   result in a single pipeline register with valid, stall and flush handling.
//
// Parameters
//   DATA_WIDTH     instruction width (only 32 is supported)
//   OPCODE_LENGTH  width of the ALU operation code (4)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   instr          instruction word from ID
//   in_valid       instr is a live instruction (0 = bubble)
//   stall          hold the register contents
//   flush          clear the register to a bubble (wins over stall)
//   out_valid      registered outputs describe a live instruction
//   Operation      ALU operation code
//   alu_src_a_pc   SrcA is the PC (AUIPC only)
//   alu_src_b_imm  SrcB is the immediate (else rs2)
//   is_branch      conditional branch; ALU result bit 0 is the taken flag
//   is_jump        JAL or JALR
//   illegal        rejected instruction trapped (ALU_ENC_ILLEGAL_TRAP_EN only)
//
// Configuration macro
//   ALU_ENC_ILLEGAL_TRAP_EN  when defined, a rejected live instruction becomes
//                            a bubble with illegal=1; when undefined it flows
//                            through as Operation 0000 with out_valid=in_valid.
// ---------------------------------------------------------------------------
module alu_op_encoder #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    instr,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     alu_src_a_pc,
    output logic                     alu_src_b_imm,
    output logic                     is_branch,
    output logic                     is_jump
`ifdef ALU_ENC_ILLEGAL_TRAP_EN
    ,
    output logic                     illegal
`endif
);

    localparam int unsigned OW = OPCODE_LENGTH;

    // RV32I major opcodes
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation codes
    localparam logic [OW-1:0] OP_AND  = OW'(4'b0000);
    localparam logic [OW-1:0] OP_XOR  = OW'(4'b0001);
    localparam logic [OW-1:0] OP_OR   = OW'(4'b0010);
    localparam logic [OW-1:0] OP_ADD  = OW'(4'b0011);
    localparam logic [OW-1:0] OP_SUB  = OW'(4'b0100);
    localparam logic [OW-1:0] OP_EQ   = OW'(4'b0101);
    localparam logic [OW-1:0] OP_NE   = OW'(4'b0110);
    localparam logic [OW-1:0] OP_LT   = OW'(4'b0111);
    localparam logic [OW-1:0] OP_GE   = OW'(4'b1000);
    localparam logic [OW-1:0] OP_SRL  = OW'(4'b1001);
    localparam logic [OW-1:0] OP_SLL  = OW'(4'b1010);
    localparam logic [OW-1:0] OP_SRA  = OW'(4'b1011);
    localparam logic [OW-1:0] OP_PASB = OW'(4'b1100);
    localparam logic [OW-1:0] OP_TRUE = OW'(4'b1111);

    // Instruction fields
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_instr_bits;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    // Register specifiers and immediates do not affect ALU control.
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // Decode result (combinational)
    logic [OW-1:0] dec_op;
    logic          dec_a_pc;
    logic          dec_b_imm;
    logic          dec_br;
    logic          dec_jmp;
    logic          dec_rej;

    // Shared R/I arithmetic mapping; alt selects SUB (f3 000) or SRA (f3 101).
    // Returns {reject, op}.
    function automatic logic [OW:0] arith_op(input logic [2:0] fn3, input logic alt);
        logic [OW:0] r;
        r = {1'b0, OP_AND};
        case (fn3)
            3'b000:  r = {1'b0, (alt ? OP_SUB : OP_ADD)};
            3'b001:  r = {1'b0, OP_SLL};
            3'b010:  r = {1'b0, OP_LT};
            3'b011:  r = {1'b1, OP_AND};   // unsigned compare not supported
            3'b100:  r = {1'b0, OP_XOR};
            3'b101:  r = {1'b0, (alt ? OP_SRA : OP_SRL)};
            3'b110:  r = {1'b0, OP_OR};
            default: r = {1'b0, OP_AND};
        endcase
        return r;
    endfunction

    // Branch condition mapping; unsigned compares rejected. Returns {reject, op}.
    function automatic logic [OW:0] branch_op(input logic [2:0] fn3);
        logic [OW:0] r;
        case (fn3)
            3'b000:  r = {1'b0, OP_EQ};
            3'b001:  r = {1'b0, OP_NE};
            3'b100:  r = {1'b0, OP_LT};
            3'b101:  r = {1'b0, OP_GE};
            default: r = {1'b1, OP_AND};
        endcase
        return r;
    endfunction

    // Instruction decode
    always_comb begin
        logic [OW:0] res;
        dec_op    = OP_AND;
        dec_a_pc  = 1'b0;
        dec_b_imm = 1'b0;
        dec_br    = 1'b0;
        dec_jmp   = 1'b0;
        dec_rej   = 1'b0;
        res       = {1'b0, OP_AND};

        case (opc)
            OPC_R: begin
                if (f7 == F7_BASE) begin
                    res = arith_op(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    res = arith_op(f3, 1'b1);
                end else begin
                    res = {1'b1, OP_AND};
                end
                dec_op  = res[OW-1:0];
                dec_rej = res[OW];
            end
            OPC_I: begin
                dec_b_imm = 1'b1;
                // f7 is shift-type only for the shift encodings; elsewhere it is immediate.
                if (f3 == 3'b001) begin
                    res = (f7 == F7_BASE) ? arith_op(f3, 1'b0) : {1'b1, OP_AND};
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_BASE) begin
                        res = arith_op(f3, 1'b0);
                    end else if (f7 == F7_ALT) begin
                        res = arith_op(f3, 1'b1);
                    end else begin
                        res = {1'b1, OP_AND};
                    end
                end else begin
                    res = arith_op(f3, 1'b0);
                end
                dec_op  = res[OW-1:0];
                dec_rej = res[OW];
            end
            OPC_LOAD, OPC_STORE: begin
                dec_op    = OP_ADD;
                dec_b_imm = 1'b1;
            end
            OPC_JALR: begin
                dec_op    = OP_ADD;
                dec_b_imm = 1'b1;
                dec_jmp   = 1'b1;
            end
            OPC_BRANCH: begin
                res     = branch_op(f3);
                dec_op  = res[OW-1:0];
                dec_rej = res[OW];
                dec_br  = 1'b1;
            end
            OPC_LUI: begin
                dec_op    = OP_PASB;
                dec_b_imm = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op    = OP_ADD;
                dec_a_pc  = 1'b1;
                dec_b_imm = 1'b1;
            end
            OPC_JAL: begin
                dec_op  = OP_TRUE;
                dec_jmp = 1'b1;
            end
            default: begin
                dec_rej = 1'b1;
            end
        endcase

        // A rejected instruction carries no operation and no controls.
        if (dec_rej) begin
            dec_op    = OP_AND;
            dec_a_pc  = 1'b0;
            dec_b_imm = 1'b0;
            dec_br    = 1'b0;
            dec_jmp   = 1'b0;
        end
    end

    // Pipeline register: flush > stall > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            Operation     <= OP_AND;
            alu_src_a_pc  <= 1'b0;
            alu_src_b_imm <= 1'b0;
            is_branch     <= 1'b0;
            is_jump       <= 1'b0;
`ifdef ALU_ENC_ILLEGAL_TRAP_EN
            illegal       <= 1'b0;
`endif
        end else if (flush || !stall) begin
            // Bubble values first; a live load overrides them below.
            out_valid     <= 1'b0;
            Operation     <= OP_AND;
            alu_src_a_pc  <= 1'b0;
            alu_src_b_imm <= 1'b0;
            is_branch     <= 1'b0;
            is_jump       <= 1'b0;
`ifdef ALU_ENC_ILLEGAL_TRAP_EN
            illegal       <= 1'b0;
            if (!flush && in_valid) begin
                if (dec_rej) begin
                    illegal <= 1'b1;
                end else begin
                    out_valid     <= 1'b1;
                    Operation     <= dec_op;
                    alu_src_a_pc  <= dec_a_pc;
                    alu_src_b_imm <= dec_b_imm;
                    is_branch     <= dec_br;
                    is_jump       <= dec_jmp;
                end
            end
`else
            // Rejected decodes are already all-zero and flow as a NOP-like AND.
            if (!flush && in_valid) begin
                out_valid     <= 1'b1;
                Operation     <= dec_op;
                alu_src_a_pc  <= dec_a_pc;
                alu_src_b_imm <= dec_b_imm;
                is_branch     <= dec_br;
                is_jump       <= dec_jmp;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_op_encoder.sv
// ---------------------------------------------------------------------------
// tb_alu_op_encoder
//   Directed bench for alu_op_encoder. Each step states the architectural
//   decode of its instruction; the bench derives the register's next value
//   from stall/flush/in_valid, queues it, and compares after the edge.
//   Honours ALU_ENC_ILLEGAL_TRAP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_alu_op_encoder;

    typedef struct packed {
        logic [3:0] op;
        logic       a_pc;
        logic       b_imm;
        logic       br;
        logic       jmp;
        logic       rej;
    } dec_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] op;
        logic       a_pc;
        logic       b_imm;
        logic       br;
        logic       jmp;
        logic       ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [3:0]  Operation;
    logic        alu_src_a_pc;
    logic        alu_src_b_imm;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    exp_t q[$];
    exp_t cur;
    exp_t zero_e;

    alu_op_encoder #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .out_valid     (out_valid),
        .Operation     (Operation),
        .alu_src_a_pc  (alu_src_a_pc),
        .alu_src_b_imm (alu_src_b_imm),
        .is_branch     (is_branch),
        .is_jump       (is_jump)
`ifdef ALU_ENC_ILLEGAL_TRAP_EN
        ,
        .illegal       (illegal)
`endif
    );

`ifndef ALU_ENC_ILLEGAL_TRAP_EN
    assign illegal = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic dec_t mk(input logic [3:0] op, input logic a, input logic b,
                                input logic br, input logic j, input logic rej);
        dec_t d;
        d.op = op; d.a_pc = a; d.b_imm = b; d.br = br; d.jmp = j; d.rej = rej;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        chk({tag, ".out_valid"}, 4'(out_valid), 4'(e.valid));
        chk({tag, ".Operation"}, Operation, e.op);
        chk({tag, ".src_a_pc"}, 4'(alu_src_a_pc), 4'(e.a_pc));
        chk({tag, ".src_b_imm"}, 4'(alu_src_b_imm), 4'(e.b_imm));
        chk({tag, ".is_branch"}, 4'(is_branch), 4'(e.br));
        chk({tag, ".is_jump"}, 4'(is_jump), 4'(e.jmp));
`ifdef ALU_ENC_ILLEGAL_TRAP_EN
        chk({tag, ".illegal"}, 4'(illegal), 4'(e.ill));
`endif
    endtask

    // One clocked step, entered and left at a falling edge.
    task automatic step(input string tag, input logic [31:0] ins, input logic v,
                        input logic st, input logic fl, input dec_t d);
        exp_t nx;
        exp_t got;
        instr = ins; in_valid = v; stall = st; flush = fl;
        nx = zero_e;
        if (fl) begin
            nx = zero_e;
        end else if (st) begin
            nx = cur;
        end else if (v) begin
`ifdef ALU_ENC_ILLEGAL_TRAP_EN
            if (d.rej) begin
                nx.ill = 1'b1;
            end else begin
                nx.valid = 1'b1; nx.op = d.op; nx.a_pc = d.a_pc;
                nx.b_imm = d.b_imm; nx.br = d.br; nx.jmp = d.jmp;
            end
`else
            nx.valid = 1'b1;
            if (!d.rej) begin
                nx.op = d.op; nx.a_pc = d.a_pc;
                nx.b_imm = d.b_imm; nx.br = d.br; nx.jmp = d.jmp;
            end
`endif
        end
        q.push_back(nx);
        cur = nx;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            got = q.pop_front();
            cmp_all(tag, got);
        end
        @(negedge clk);
    endtask

    initial begin
        dec_t d_add, d_sub, d_xor, d_srai, d_lui, d_beq, d_blt, d_bge, d_rej;
        dec_t d_jal, d_jalr, d_auipc, d_lw, d_sw;
        zero_e   = '0;
        cur      = '0;
        d_add    = mk(4'b0011, 0, 0, 0, 0, 0);
        d_sub    = mk(4'b0100, 0, 0, 0, 0, 0);
        d_xor    = mk(4'b0001, 0, 0, 0, 0, 0);
        d_srai   = mk(4'b1011, 0, 1, 0, 0, 0);
        d_lui    = mk(4'b1100, 0, 1, 0, 0, 0);
        d_beq    = mk(4'b0101, 0, 0, 1, 0, 0);
        d_blt    = mk(4'b0111, 0, 0, 1, 0, 0);
        d_bge    = mk(4'b1000, 0, 0, 1, 0, 0);
        d_jal    = mk(4'b1111, 0, 0, 0, 1, 0);
        d_jalr   = mk(4'b0011, 0, 1, 0, 1, 0);
        d_auipc  = mk(4'b0011, 1, 1, 0, 0, 0);
        d_lw     = mk(4'b0011, 0, 1, 0, 0, 0);
        d_sw     = mk(4'b0011, 0, 1, 0, 0, 0);
        d_rej    = mk(4'b0000, 0, 0, 0, 0, 1);

        rst_n = 1'b0; instr = 32'h0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1 cmp_all("reset_init", zero_e);
        @(negedge clk);
        rst_n = 1'b1;

        // Load something, then assert reset mid-cycle with a live input.
        step("add", 32'h00B50533, 1, 0, 0, d_add);
        instr = 32'h0000006F; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 cmp_all("reset_async", zero_e);
        @(posedge clk);
        #1 cmp_all("reset_held", zero_e);
        @(negedge clk);
        rst_n = 1'b1;
        #1 cmp_all("reset_release", zero_e);
        cur = zero_e;
        @(negedge clk);

        // Decode sweep, back to back
        step("sub",   32'h40B50533, 1, 0, 0, d_sub);
        step("srai",  32'h4055D593, 1, 0, 0, d_srai);
        step("lui",   32'h00001137, 1, 0, 0, d_lui);
        step("xor",   32'h00B54533, 1, 0, 0, d_xor);
        step("lw",    32'h0005A503, 1, 0, 0, d_lw);
        step("sw",    32'h00A5A023, 1, 0, 0, d_sw);

        // Branches
        step("beq",   32'h00B50463, 1, 0, 0, d_beq);
        step("blt",   32'h00B54463, 1, 0, 0, d_blt);
        step("bge",   32'h00B55463, 1, 0, 0, d_bge);
        step("bltu",  32'h00B56463, 1, 0, 0, d_rej);

        // Stall holds through changing instr, then stall+flush clears
        step("st_add",  32'h00B50533, 1, 0, 0, d_add);
        step("stall1",  32'h40B50533, 1, 1, 0, d_sub);
        step("stall2",  32'h00001137, 1, 1, 0, d_lui);
        step("stall3",  32'h0000006F, 1, 1, 0, d_jal);
        step("stflush", 32'h0000006F, 1, 1, 1, d_jal);
        step("post_fl", 32'h40B50533, 1, 0, 0, d_sub);
        step("flush",   32'h00B50533, 1, 0, 1, d_add);
        step("bubble",  32'h00B50533, 0, 0, 0, d_add);

        // Jumps
        step("jal",   32'h0000006F, 1, 0, 0, d_jal);
        step("jalr",  32'h00008067, 1, 0, 0, d_jalr);
        step("auipc", 32'h00000517, 1, 0, 0, d_auipc);

        // Rejected instructions; stall holds the illegal state, next load clears it
        step("op7f",    32'h0000007F, 1, 0, 0, d_rej);
        step("sltu",    32'h00B53533, 1, 0, 0, d_rej);
        step("ill_st",  32'h00B50533, 1, 1, 0, d_add);
        step("ill_clr", 32'h00B50533, 1, 0, 0, d_add);
        step("ill_rej", 32'h00B53533, 1, 0, 0, d_rej);
        step("ill_fl",  32'h00B53533, 1, 0, 1, d_rej);
        step("rej_bub", 32'h00B53533, 0, 0, 0, d_rej);

        // Reset during a stall
        step("pre_st", 32'h00000517, 1, 0, 0, d_auipc);
        step("st_hold", 32'h00B50533, 1, 1, 0, d_add);
        #2 rst_n = 1'b0;
        #1 cmp_all("reset_mid_stall", zero_e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
